uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART `rx` core. It arms and re-arms the receiver through `rx_enable`, captures each completed frame into a FIFO, and presents the frames to the system on a valid/ready stream. It also classifies receiver error pulses into sticky status bits and counters. A watchdog recovers the receiver from a stuck frame.

---
 rtl/uart_rx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Purpose : arms the UART rx core, buffers received frames, classifies errors, recovers stuck frames.
// Latency : rx_valid at cycle N -> m_valid with the word at cycle N+1.
// Backpres: m_ready low holds the FIFO; when full, a new frame is dropped and flagged as overflow.
//
// Ports:
//   Clk, rst_n           clock and asynchronous active-low reset
//   ctrl_en, clr_status  controller enable; one-cycle clear of status/err_cnt
//   rx_enable            enable for the rx core (low in OFF and FLUSH)
//   rx_valid/active/word/error  frame pulse, busy level, frame data and error pulse from the rx core
//   m_data/m_valid/m_ready      FIFO head stream towards the system
//   fifo_level, status, frame_cnt, err_cnt   occupancy, sticky flags and counters
module uart_rx_ctrl #(
  parameter int WORD_W      = 10,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 400,
  parameter int FLUSH_CYC   = 2
) (
  input  logic                          Clk,
  input  logic                          rst_n,
  input  logic                          ctrl_en,
  input  logic                          clr_status,
  output logic                          rx_enable,
  input  logic                          rx_valid,
  input  logic                          rx_active,
  input  logic [WORD_W-1:0]             rx_word,
  input  logic [2:0]                    rx_error,
  output logic [WORD_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [4:0]                    status,
  output logic [15:0]                   frame_cnt,
  output logic [7:0]                    err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int FL_W  = $clog2(FLUSH_CYC + 1);

  localparam logic [PTR_W:0]  FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [FL_W-1:0] FL_LAST  = FL_W'(FLUSH_CYC - 1);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_LISTEN = 3'd2;
  localparam logic [2:0] ST_RECV   = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;

  logic [2:0]      state, next_state;
  logic [WD_W-1:0] wd;
  logic [FL_W-1:0] flush_cnt;
  logic            arm_cnt;
  logic            timeout;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      ST_OFF:    if (ctrl_en) next_state = ST_ARM;
      ST_ARM:    if (arm_cnt) next_state = ST_LISTEN;
      ST_LISTEN: if (rx_active) next_state = ST_RECV;
      ST_RECV: begin
        // A normal end of frame takes precedence over the watchdog.
        if (rx_valid || (rx_error != 3'b000) || !rx_active) begin
          next_state = ST_LISTEN;
        end else if (wd == WD_LAST) begin
          timeout    = 1'b1;
          next_state = ST_FLUSH;
        end
      end
      ST_FLUSH:  if (flush_cnt == FL_LAST) next_state = ST_ARM;
      default:   next_state = ST_OFF;
    endcase
    if (!ctrl_en) next_state = ST_OFF;
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      wd        <= '0;
      flush_cnt <= '0;
      arm_cnt   <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == ST_RECV && state != ST_RECV) begin
        wd <= '0;
      end else if (state == ST_RECV && rx_active) begin
        wd <= wd + WD_W'(1);
      end
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FL_W'(1) : '0;
      // ARM always lasts two cycles: arm_cnt marks the second one.
      arm_cnt   <= (state == ST_ARM);
    end
  end

  assign rx_enable = (state == ST_ARM) || (state == ST_LISTEN) || (state == ST_RECV);

  // --------------------------------------------------------------- FIFO
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic              full, pop, push, overflow;

  assign full     = (count == FULL_LVL);
  assign pop      = m_valid && m_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push     = rx_valid && (!full || pop);
  assign overflow = rx_valid && full && !pop;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rx_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign m_valid    = (count != '0);
  assign m_data     = mem[rd_ptr];
  assign fifo_level = count;

  // ------------------------------------------------- status and counters
  logic [4:0] status_nxt;
  logic [7:0] err_base, err_nxt;
  logic       err_evt;

  always_comb begin
    // Clear first, then OR in this cycle's events so a set wins over clear.
    status_nxt = (clr_status ? 5'b0 : status) | {overflow, timeout, rx_error};
    err_base   = clr_status ? 8'd0 : err_cnt;
    // Any combination of events in one cycle counts once.
    err_evt    = (rx_error != 3'b000) || overflow || timeout;
    err_nxt    = (err_evt && err_base != 8'hFF) ? err_base + 8'd1 : err_base;
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      status    <= '0;
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      status    <= status_nxt;
      err_cnt   <= err_nxt;
      frame_cnt <= frame_cnt + 16'(push);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Purpose : directed and random stimulus against a queue-based reference model of uart_rx_ctrl.
// Latency : outputs compared 1 time unit after each rising edge.
// Backpres: m_ready driven directly by the stimulus.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int TOUT  = 400;
  localparam int FLUSH = 2;

  logic       Clk, rst_n, ctrl_en, clr_status, rx_enable;
  logic       rx_valid, rx_active, m_valid, m_ready;
  logic [9:0] rx_word, m_data;
  logic [2:0] rx_error;
  logic [3:0] fifo_level;
  logic [4:0] status;
  logic [15:0] frame_cnt;
  logic [7:0] err_cnt;

  uart_rx_ctrl #(.WORD_W(10), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT), .FLUSH_CYC(FLUSH)) dut (
    .Clk(Clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .clr_status(clr_status),
    .rx_enable(rx_enable), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_word(rx_word), .rx_error(rx_error), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .fifo_level(fifo_level), .status(status),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 Clk = ~Clk;

  // Reference model
  logic [9:0] mq[$];
  logic [4:0] ms;
  int         mf, me;
  logic       en_exp;
  int         n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rx_enable", 32'(rx_enable), 32'(en_exp));
    chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    chk("fifo_level", 32'(fifo_level), mq.size());
    if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
    chk("status", 32'(status), 32'(ms));
    chk("frame_cnt", 32'(frame_cnt), mf);
    chk("err_cnt", 32'(err_cnt), me);
  endtask

  // Advance one clock; the model consumes the inputs presented before the edge.
  task automatic step(input bit tout);
    int sz;
    bit pop, acc, ovf;
    sz  = mq.size();
    pop = (sz > 0) && m_ready;
    acc = rx_valid && ((sz < DEPTH) || pop);
    ovf = rx_valid && !acc;
    if (clr_status) begin ms = 0; me = 0; end
    if (pop) mq.delete(0);
    if (acc) begin mq.push_back(rx_word); mf = (mf + 1) % 65536; end
    ms = ms | {ovf, tout, rx_error};
    if ((rx_error != 0 || ovf || tout) && me < 255) me++;
    @(posedge Clk);
    #1;
    rx_valid = 0; rx_error = 0; clr_status = 0;
    check_all();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    Clk = 0; rst_n = 0; ctrl_en = 0; clr_status = 0;
    rx_valid = 0; rx_active = 0; rx_word = 0; rx_error = 0; m_ready = 0;
    ms = 0; mf = 0; me = 0; en_exp = 0;

    // Reset values
    #2;
    check_all();
    chk("rst_m_data", 32'(m_data), 0);
    #10 rst_n = 1;

    // OFF, then ARM for two cycles, then LISTEN
    step(0);
    ctrl_en = 1; en_exp = 1;
    step(0); step(0); step(0);

    // Basic frame
    rx_active = 1; step(0);
    rx_valid = 1; rx_word = 10'h2A5; rx_active = 0; step(0);
    chk("basic_data", 32'(m_data), 32'h2A5);
    chk("basic_frames", 32'(frame_cnt), 1);
    chk("basic_level", 32'(fifo_level), 1);
    m_ready = 1; step(0);
    chk("basic_drained", 32'(fifo_level), 0);
    m_ready = 0;

    // Overflow: nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      rx_valid = 1; rx_word = 10'(i); step(0);
    end
    chk("ovf_level", 32'(fifo_level), 8);
    chk("ovf_flag", 32'(status[4]), 1);
    chk("ovf_errcnt", 32'(err_cnt), 1);
    m_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_order", 32'(m_data), i);
      step(0);
    end
    m_ready = 0;
    clr_status = 1; step(0);
    chk("clr_status", 32'(status), 0);

    // Error classification
    rx_error = 3'b001; step(0);
    rx_error = 3'b100; step(0);
    rx_error = 3'b101; step(0);
    chk("err_status", 32'(status), 32'b00101);
    chk("err_count", 32'(err_cnt), 3);
    clr_status = 1; step(0);
    chk("err_clr", 32'(err_cnt), 0);

    // Clear and set in the same cycle: set wins from zero
    rx_error = 3'b010; step(0);
    clr_status = 1; rx_error = 3'b001; step(0);
    chk("clr_vs_set", 32'(status), 32'b00001);

    // Saturation of err_cnt
    for (int i = 0; i < 260; i++) begin
      rx_error = 3'b001; step(0);
    end
    chk("err_sat", 32'(err_cnt), 255);
    clr_status = 1; step(0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      rx_valid = 1; rx_word = 10'($urandom); step(0);
    end
    rx_valid = 1; rx_word = 10'h155; m_ready = 1; step(0);
    chk("full_pp_level", 32'(fifo_level), 8);
    chk("full_pp_ovf", 32'(status[4]), 0);
    for (int i = 0; i < DEPTH; i++) step(0);
    m_ready = 0;

    // Random traffic in LISTEN
    for (int i = 0; i < 300; i++) begin
      rx_valid   = ($urandom % 3) == 0;
      rx_word    = 10'($urandom);
      m_ready    = ($urandom % 2) == 0;
      rx_error   = (($urandom % 10) == 0) ? 3'($urandom) : 3'b000;
      clr_status = ($urandom % 40) == 0;
      step(0);
    end
    m_ready = 1;
    for (int i = 0; i < DEPTH; i++) step(0);
    m_ready = 0;
    clr_status = 1; step(0);

    // Watchdog: RECV for TOUT cycles, FLUSH for two, ARM for two
    rx_active = 1; step(0);
    for (int i = 0; i < TOUT - 1; i++) step(0);
    chk("wd_not_yet", 32'(status[3]), 0);
    en_exp = 0; step(1);
    chk("wd_flag", 32'(status[3]), 1);
    rx_active = 0; step(0);
    en_exp = 1; step(0); step(0); step(0);

    // ctrl_en dropped during RECV
    rx_valid = 1; rx_word = 10'h3C3; step(0);
    rx_active = 1; step(0);
    ctrl_en = 0; en_exp = 0; step(0);
    chk("off_retained", 32'(fifo_level), 1);
    rx_active = 0; step(0);
    ctrl_en = 1; en_exp = 1; step(0); step(0); step(0);
    rx_active = 1; step(0);

    // Asynchronous reset mid-frame
    #2 rst_n = 0;
    #1;
    mq.delete(); ms = 0; mf = 0; me = 0; en_exp = 0;
    check_all();
    chk("arst_m_data", 32'(m_data), 0);
    chk("arst_m_valid", 32'(m_valid), 0);
    #3 rst_n = 1; rx_active = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
